// File: rtl/crc32_if.sv
// Frame/payload bus between a pixel-stream source (master) and the crc32 engine (slave).
// Carries picture size, frame start, the IDAT word stream and the registered CRC results.
interface crc32_if #(
  parameter int DATA_WD     = 32,
  parameter int SIZE_PIC_WD = 32
);
  logic [SIZE_PIC_WD-1:0] w_i;
  logic [SIZE_PIC_WD-1:0] h_i;
  logic                   start_i;
  logic                   val_i;
  logic [DATA_WD-1:0]     dat_i;
  logic                   lst_i;
  logic                   done_o;
  logic                   val_o;
  logic [DATA_WD-1:0]     dat_o;

  modport master (
    output w_i, h_i, start_i, val_i, dat_i, lst_i,
    input  done_o, val_o, dat_o
  );

  modport slave (
    input  w_i, h_i, start_i, val_i, dat_i, lst_i,
    output done_o, val_o, dat_o
  );
endinterface

// File: rtl/crc32.sv
// PNG chunk CRC-32 engine: optional IHDR chunk (macro CRC32_IHDR_EN), then "IDAT" + payload words.
// Registered outputs; IDAT CRC one cycle after the lst_i word is accepted; no backpressure (val_i gaps only).
module crc32 #(
  parameter int DATA_WD     = 32,
  parameter int SIZE_PIC_WD = 32
) (
  input  logic   clk,
  input  logic   rstn,
  crc32_if.slave bus
);
  localparam logic [DATA_WD-1:0] POLY     = 32'hEDB88320;
  localparam logic [DATA_WD-1:0] CRC_INIT = 32'hFFFFFFFF;
  localparam logic [DATA_WD-1:0] IDAT_TAG = 32'h49444154;
`ifdef CRC32_IHDR_EN
  localparam logic [DATA_WD-1:0] IHDR_TAG = 32'h49484452;
  localparam logic [DATA_WD-1:0] IHDR_FMT = 32'h08020000;
`endif

  if (DATA_WD != 32 || SIZE_PIC_WD > DATA_WD) begin : g_param_chk
    $error("crc32: DATA_WD must be 32 and SIZE_PIC_WD must fit in one data word");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_IHDR, S_IHDR_CRC, S_IDAT_TYPE, S_DATA, S_IDAT_CRC
  } state_e;

  // Reflected CRC: bytes taken MSB-first from the word, each byte LSB-first; all_bytes=0 folds only the top byte.
  function automatic logic [DATA_WD-1:0] crc_upd(input logic [DATA_WD-1:0] crc,
                                                 input logic [DATA_WD-1:0] dat,
                                                 input logic               all_bytes);
    logic [DATA_WD-1:0] c;
    c = crc;
    for (int b = 0; b < 4; b++) begin
      if (b == 0 || all_bytes) begin
        for (int i = 0; i < 8; i++) begin
          c = {1'b0, c[DATA_WD-1:1]} ^ ((c[0] ^ dat[DATA_WD-8-8*b+i]) ? POLY : '0);
        end
      end
    end
    return c;
  endfunction

  state_e             state_q, state_d;
  logic [DATA_WD-1:0] crc_q, crc_d, crc_nx;
  logic               val_q, val_d;
  logic               done_q, done_d;
  logic [DATA_WD-1:0] dat_q, dat_d;
  logic               feed_vld;
  logic               feed_all;
  logic [DATA_WD-1:0] feed_dat;
`ifdef CRC32_IHDR_EN
  logic [2:0]             cnt_q, cnt_d;
  logic [SIZE_PIC_WD-1:0] w_q, w_d;
  logic [SIZE_PIC_WD-1:0] h_q, h_d;
`endif

  // feed_vld is the chunk-valid flag: high whenever a word is folded into the running CRC.
  always_comb begin
    feed_vld = 1'b0;
    feed_all = 1'b1;
    feed_dat = '0;
    case (state_q)
`ifdef CRC32_IHDR_EN
      S_IHDR: begin
        feed_vld = 1'b1;
        case (cnt_q)
          3'd0:    feed_dat = IHDR_TAG;
          3'd1:    feed_dat = DATA_WD'(w_q);
          3'd2:    feed_dat = DATA_WD'(h_q);
          3'd3:    feed_dat = IHDR_FMT;
          default: feed_all = 1'b0;
        endcase
      end
`endif
      S_IDAT_TYPE: begin
        feed_vld = 1'b1;
        feed_dat = IDAT_TAG;
      end
      S_DATA: begin
        feed_vld = bus.val_i;
        feed_dat = bus.dat_i;
      end
      default: ;
    endcase
  end

  assign crc_nx = feed_vld ? crc_upd(crc_q, feed_dat, feed_all) : crc_q;

  always_comb begin
    state_d = state_q;
    crc_d   = crc_nx;
    val_d   = 1'b0;
    done_d  = 1'b0;
    dat_d   = '0;
`ifdef CRC32_IHDR_EN
    cnt_d   = cnt_q;
    w_d     = w_q;
    h_d     = h_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          crc_d   = CRC_INIT;
`ifdef CRC32_IHDR_EN
          w_d     = bus.w_i;
          h_d     = bus.h_i;
          cnt_d   = '0;
          state_d = S_IHDR;
`else
          state_d = S_IDAT_TYPE;
`endif
        end
      end
`ifdef CRC32_IHDR_EN
      S_IHDR: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd4) begin
          state_d = S_IHDR_CRC;
          val_d   = 1'b1;
          dat_d   = ~crc_nx;
        end
      end
      S_IHDR_CRC: begin
        crc_d   = CRC_INIT;
        state_d = S_IDAT_TYPE;
      end
`endif
      S_IDAT_TYPE: state_d = S_DATA;
      S_DATA: begin
        if (bus.val_i && bus.lst_i) begin
          state_d = S_IDAT_CRC;
          val_d   = 1'b1;
          done_d  = 1'b1;
          dat_d   = ~crc_nx;
        end
      end
      S_IDAT_CRC: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q <= S_IDLE;
      crc_q   <= CRC_INIT;
      val_q   <= 1'b0;
      done_q  <= 1'b0;
      dat_q   <= '0;
`ifdef CRC32_IHDR_EN
      cnt_q   <= '0;
      w_q     <= '0;
      h_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      val_q   <= val_d;
      done_q  <= done_d;
      dat_q   <= dat_d;
`ifdef CRC32_IHDR_EN
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      h_q     <= h_d;
`endif
    end
  end

  assign bus.val_o  = val_q;
  assign bus.done_o = done_q;
  assign bus.dat_o  = dat_q;
endmodule

// File: tb/tb_crc32.sv
// Randomized frames against a table-driven byte-stream PNG CRC model; a negedge monitor
// pops expected (crc, done, cycle) entries whenever val_o is seen.
module tb_crc32;
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  crc32_if #(.DATA_WD(32), .SIZE_PIC_WD(32)) cif ();
  crc32 #(.DATA_WD(32), .SIZE_PIC_WD(32)) dut (.clk(clk), .rstn(rstn), .bus(cif));

`ifdef CRC32_IHDR_EN
  localparam int LEAD = 7;
`else
  localparam int LEAD = 1;
`endif

  typedef struct {
    logic [31:0] dat;
    logic        done;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] crc_tbl[256];
  logic [7:0]  model_bytes[$];
  logic [31:0] words[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model_crc();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (model_bytes[k]) c = crc_tbl[c[7:0] ^ model_bytes[k]] ^ (c >> 8);
    return ~c;
  endfunction

  task automatic add_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) model_bytes.push_back(w[8*k +: 8]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cif.start_i = 1'b0;
    cif.val_i   = 1'b0;
    cif.lst_i   = 1'b0;
    cif.dat_i   = '0;
  endtask

  // Drives one frame using the module-level words queue; abort_at >= 0 resets before that word.
  task automatic run_frame(input logic [31:0] w, input logic [31:0] h, input int max_gap,
                           input int abort_at, input bit poke_start);
    cif.w_i     = w;
    cif.h_i     = h;
    cif.start_i = 1'b1;
`ifdef CRC32_IHDR_EN
    model_bytes.delete();
    add_word(32'h49484452);
    add_word(w);
    add_word(h);
    add_word(32'h08020000);
    model_bytes.push_back(8'h00);
    if (w == 32'd1 && h == 32'd1) exp_q.push_back('{32'h907753DE, 1'b0, cyc + 6});
    else                          exp_q.push_back('{model_crc(), 1'b0, cyc + 6});
`endif
    tick();
    cif.start_i = 1'b0;
    repeat (LEAD) tick();
    model_bytes.delete();
    add_word(32'h49444154);
    if (poke_start) begin
      cif.start_i = 1'b1;
      tick();
      cif.start_i = 1'b0;
    end
    foreach (words[k]) begin
      if (abort_at == k) begin
        rstn = 1'b1;
        clear_inputs();
        tick();
        tick();
        rstn = 1'b0;
        tick();
        return;
      end
      repeat ($urandom_range(max_gap, 0)) begin
        cif.val_i = 1'b0;
        cif.lst_i = 1'($urandom_range(1, 0));
        cif.dat_i = $urandom;
        tick();
      end
      cif.val_i = 1'b1;
      cif.dat_i = words[k];
      cif.lst_i = (k == words.size() - 1);
      add_word(words[k]);
      if (k == words.size() - 1) exp_q.push_back('{model_crc(), 1'b1, cyc + 1});
      tick();
    end
    cif.val_i = 1'b0;
    cif.lst_i = 1'b0;
    if (poke_start) cif.start_i = 1'b1;
    tick();
    cif.start_i = 1'b0;
    tick();
    tick();
  endtask

  task automatic rand_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  always @(negedge clk) begin
    if (rstn === 1'b0) begin
      vectors++;
      if (cif.val_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_out: got val_o=1 dat_o=%08h done_o=%b at cyc %0d, expected no output",
                   cif.dat_o, cif.done_o, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (cif.dat_o !== mon_e.dat || cif.done_o !== mon_e.done || cyc != mon_e.cyc) begin
            miscompares++;
            $display("FAIL crc_out: got dat_o=%08h done_o=%b cyc=%0d, expected dat_o=%08h done_o=%b cyc=%0d",
                     cif.dat_o, cif.done_o, cyc, mon_e.dat, mon_e.done, mon_e.cyc);
          end
        end
      end else if (cif.val_o !== 1'b0 || cif.dat_o !== 32'd0 || cif.done_o !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_out: got val_o=%b dat_o=%08h done_o=%b at cyc %0d, expected 0/0/0",
                 cif.val_o, cif.dat_o, cif.done_o, cyc);
      end
    end
  end

  initial begin
    logic [31:0] c;
    logic [31:0] w, h;
    int t;
    for (int n = 0; n < 256; n++) begin
      c = 32'(n);
      for (int b = 0; b < 8; b++) c = c[0] ? (32'hEDB88320 ^ (c >> 1)) : (c >> 1);
      crc_tbl[n] = c;
    end
    rstn    = 1'b1;
    cif.w_i = '0;
    cif.h_i = '0;
    clear_inputs();
    repeat (5) tick();
    @(negedge clk);
    vectors++;
    if (cif.val_o !== 1'b0) begin miscompares++; $display("FAIL rst_val: got %b, expected 0", cif.val_o); end
    vectors++;
    if (cif.done_o !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b, expected 0", cif.done_o); end
    vectors++;
    if (cif.dat_o !== 32'd0) begin miscompares++; $display("FAIL rst_dat: got %08h, expected 0", cif.dat_o); end
    rstn = 1'b0;
    tick();

    // val_i/lst_i in IDLE must not start anything
    repeat (4) begin
      cif.val_i = 1'b1;
      cif.lst_i = 1'b1;
      cif.dat_i = $urandom;
      tick();
    end
    clear_inputs();
    repeat (3) tick();

    rand_words(2);
    run_frame(32'd1, 32'd1, 1, -1, 1'b0);

    words.delete();
    words.push_back(32'h04090409);
    run_frame(32'd256, 32'd256, 0, -1, 1'b0);

    w = $urandom;
    h = $urandom;
    rand_words(6);
    run_frame(w, h, 3, -1, 1'b1);
    run_frame(w, h, 0, -1, 1'b0);

    rand_words(5);
    run_frame($urandom, $urandom, 2, 3, 1'b0);
    rand_words(4);
    run_frame($urandom, $urandom, 3, -1, 1'b0);

    for (int f = 0; f < 5; f++) begin
      rand_words(int'($urandom_range(8, 1)));
      run_frame($urandom, $urandom, 3, -1, f[0]);
    end

    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      tick();
      t++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d outputs still pending, expected 0", exp_q.size());
    end
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
